// File: rtl/div32_seq.sv
// -----------------------------------------------------------------------------
// div32_seq -- iterative W-bit integer divider (restoring, one quotient bit per
// clock). This is the arithmetic inverse of the combinational Mul32 multiplier
// and sits beside it in the execute stage.
//
// The operation takes W+1 clock edges from the start edge to the done pulse:
//   E0       : operands captured as magnitudes, result signs and the
//              divide-by-zero flag remembered, counter loaded with W
//   E1..EW   : one restoring step per edge
//   EW+1     : sign correction, quo/rem/dbz registered, done pulses, busy drops
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  synchronous reset, active-low
//   start      in   1  request; sampled only while busy=0
//   is_signed  in   1  1: two's-complement divide, 0: unsigned (captured with start)
//   op1        in   W  dividend (captured with start)
//   op2        in   W  divisor  (captured with start)
//   busy       out  1  operation in progress
//   done       out  1  one-cycle pulse: quo/rem/dbz valid
//   quo        out  W  quotient, held until the next done
//   rem        out  W  remainder, held until the next done
//   dbz        out  1  divide-by-zero flag for the result on quo/rem
// -----------------------------------------------------------------------------
module div32_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dbz
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    // The counter has to hold the value W itself, hence W+1 codes.
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Magnitude of a value that is two's complement only in signed mode.
    // The most negative number maps onto itself. Read as an unsigned W-bit
    // magnitude that is still the correct value 2**(W-1), so the signed
    // overflow case needs no special handling anywhere in the datapath.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v,
                                               input logic         sgn_mode);
        magnitude = (sgn_mode && v[W-1]) ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's-complement negation used by the final sign correction.
    function automatic logic [W-1:0] cond_negate(input logic [W-1:0] v,
                                                 input logic         neg);
        cond_negate = neg ? (~v + 1'b1) : v;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;

    // Partial remainder. Only the trial subtraction needs the extra bit, since
    // the registered value is always smaller than the divisor.
    logic [W-1:0]  prem_q,     prem_d;

    // Dividend magnitude. Quotient bits shift in from the right as dividend
    // bits leave on the left, so after W steps this register holds the
    // quotient magnitude.
    logic [W-1:0]  dvd_q,      dvd_d;
    logic [W-1:0]  dvs_q,      dvs_d;

    logic          neg_quo_q,  neg_quo_d;   // quotient must be negated
    logic          neg_rem_q,  neg_rem_d;   // remainder must be negated
    logic          dbz_pend_q, dbz_pend_d;  // divide-by-zero of the op in flight

    logic          done_q,     done_d;
    logic [W-1:0]  quo_q,      quo_d;
    logic [W-1:0]  rem_q,      rem_d;
    logic          dbz_q,      dbz_d;

    // -------------------------------------------------------------------------
    // One restoring step
    // -------------------------------------------------------------------------
    logic [W:0]   shifted;     // {prem, next dividend bit}
    logic [W:0]   trial;       // shifted - divisor, MSB set means negative
    logic         trial_ok;    // subtraction did not go negative
    logic [W-1:0] step_prem;
    logic [W-1:0] step_dvd;

    always_comb begin
        shifted   = {prem_q, dvd_q[W-1]};
        trial     = shifted - {1'b0, dvs_q};
        trial_ok  = ~trial[W];
        // If the shifted value ever reaches 2**W the trial is necessarily
        // non-negative, so dropping the top bit when restoring is safe.
        step_prem = trial_ok ? trial[W-1:0] : shifted[W-1:0];
        step_dvd  = {dvd_q[W-2:0], trial_ok};
    end

    // -------------------------------------------------------------------------
    // Final result formation
    // -------------------------------------------------------------------------
    logic [W-1:0] fin_quo;
    logic [W-1:0] fin_rem;

    always_comb begin
        // With a zero divisor every trial succeeds, so the restoring loop
        // leaves the dividend magnitude in prem and all ones in the quotient.
        // Re-applying the dividend sign to prem then gives back op1 exactly.
        // Only the quotient needs forcing, because a negative dividend would
        // otherwise flip it.
        fin_rem = cond_negate(prem_q, neg_rem_q);
        if (dbz_pend_q) begin
            fin_quo = '1;
        end else begin
            fin_quo = cond_negate(dvd_q, neg_quo_q);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prem_d     = prem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        done_d     = 1'b0;          // done is a single-cycle pulse
        quo_d      = quo_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                // A start arriving in the done cycle is accepted here too,
                // because busy is already low; done still clears by default.
                if (start) begin
                    state_d    = S_CALC;
                    cnt_d      = CNT_LOAD;
                    prem_d     = '0;
                    dvd_d      = magnitude(op1, is_signed);
                    dvs_d      = magnitude(op2, is_signed);
                    neg_quo_d  = is_signed & (op1[W-1] ^ op2[W-1]);
                    neg_rem_d  = is_signed & op1[W-1];
                    dbz_pend_d = (op2 == '0);
                end
            end

            S_CALC: begin
                // start is not looked at in this state: requests made while
                // busy are dropped, not queued.
                if (cnt_q != CNT_ZERO) begin
                    prem_d = step_prem;
                    dvd_d  = step_dvd;
                    cnt_d  = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    quo_d   = fin_quo;
                    rem_d   = fin_rem;
                    dbz_d   = dbz_pend_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset aborts an operation in flight; no done pulse follows.
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            prem_q     <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            done_q     <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prem_q     <= prem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            done_q     <= done_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy = (state_q == S_CALC);
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// -----------------------------------------------------------------------------
// tb_div32_seq -- self-checking bench for div32_seq.
// Stimulus pushes the expected result of every accepted request into a queue;
// an independent monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_div32_seq;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;

    div32_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .quo       (quo),
        .rem       (rem),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain arithmetic plus the zero-divisor and overflow rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
        exp_t e;
        if (b == '0) begin
            e.quo = '1;
            e.rem = a;
            e.dbz = 1'b1;
        end else if (s && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            e.quo = a;
            e.rem = '0;
            e.dbz = 1'b0;
        end else if (s) begin
            e.quo = $signed(a) / $signed(b);
            e.rem = $signed(a) % $signed(b);
            e.dbz = 1'b0;
        end else begin
            e.quo = a / b;
            e.rem = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compares every done against the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                check("done_single_cycle", W'(prev_done), W'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: quo=0x%08h rem=0x%08h with no request outstanding (t=%0t)",
                             quo, rem, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("quo", quo, e.quo);
                    check("rem", rem, e.rem);
                    check("dbz", W'(dbz), W'(e.dbz));
                end
            end
            prev_done = rst_n && done;
        end
    end

    // Drive one start edge; expected result queued only when acceptance is expected.
    // Returns just after that edge with the operand inputs scrambled.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic accept);
        @(negedge clk);
        op1       = a;
        op2       = b;
        is_signed = s;
        start     = 1'b1;
        if (accept) exp_q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        start     = 1'b0;
        op1       = $urandom;
        op2       = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Count edges until done is seen (bounded); busy must stay high before it.
    task automatic wait_done(output int lat);
        logic busy_bad;
        lat      = 0;
        busy_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) busy_bad = 1'b1;
        end while (!done && lat < 3 * LAT);
        check("busy_while_calc", W'(busy_bad), W'(0));
        check("busy_at_done", W'(busy), W'(0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int           lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_quo",  quo, '0);
        check("rst_rem",  rem, '0);
        check("rst_dbz",  W'(dbz), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // T1: basic unsigned with latency
        start_op(32'h3F, 32'h7, 1'b0, 1'b1);
        wait_done(lat);
        check("t1_latency", W'(lat), W'(LAT));

        // T2: unsigned large, signed negative dividend
        start_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1);
        wait_done(lat);
        start_op(32'hFFFF_FFF9, 32'h2, 1'b1, 1'b1);
        wait_done(lat);

        // T3: divide by zero both modes, signed overflow
        start_op(32'h5, 32'h0, 1'b0, 1'b1);
        wait_done(lat);
        check("t3_dbz_latency", W'(lat), W'(LAT));
        start_op(32'h5, 32'h0, 1'b1, 1'b1);
        wait_done(lat);
        start_op(32'hFFFF_FFFB, 32'h0, 1'b1, 1'b1);
        wait_done(lat);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done(lat);

        // T4: start during busy is ignored
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        check("t4_busy_mid", W'(busy), W'(1));
        start_op(32'd9, 32'd3, 1'b0, 1'b0);
        wait_done(lat);
        check("t4_latency", W'(lat), W'(LAT - 10));

        // T5: back-to-back, new start in the done cycle; first result held
        start_op(32'd1000, 32'd3, 1'b0, 1'b1);
        wait_done(lat);
        start_op(32'd7, 32'd7, 1'b0, 1'b1);
        check("t5_done_cleared", W'(done), W'(0));
        repeat (5) @(posedge clk);
        #1;
        check("t5_quo_held", quo, 32'd333);
        check("t5_rem_held", rem, 32'd1);
        wait_done(lat);
        check("t5_latency", W'(lat), W'(LAT - 5));

        // T6: reset mid-operation aborts without done
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t6_busy", W'(busy), W'(0));
        check("t6_done", W'(done), W'(0));
        check("t6_quo",  quo, '0);
        check("t6_rem",  rem, '0);
        check("t6_dbz",  W'(dbz), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * LAT) @(posedge clk);
        #1;
        check("t6_quiet_quo", quo, '0);
        check("t6_quiet_busy", W'(busy), W'(0));
        start_op(32'd9, 32'd3, 1'b0, 1'b1);
        wait_done(lat);
        check("t6_latency", W'(lat), W'(LAT));

        // Random sweep with corner-case biasing
        for (int i = 0; i < 1800; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                4: a = '0;
                5: b = -($urandom_range(1, 15));
                default: ;
            endcase
            start_op(a, b, s, 1'b1);
            wait_done(lat);
            if (lat != LAT) check("rand_latency", W'(lat), W'(LAT));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
